// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per transaction, load extension, and
// misaligned handling (byte-beat split or fault report).
module load_store_unit #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic        memwrite,
    output logic [31:0] mem_addr,
    output logic [1:0]  load_type,
    output logic [1:0]  store_type,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned TYPE_W = 2;
    localparam logic [TYPE_W-1:0] TYPE_WORD = 2'b00;
    localparam logic [TYPE_W-1:0] TYPE_HALF = 2'b01;
    localparam logic [TYPE_W-1:0] TYPE_BYTE = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic              split_q, split_d;
    logic [1:0]        beat_q, beat_d;
    logic [1:0]        last_beat_q, last_beat_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_mis_q, resp_mis_d;
    logic              resp_ill_q, resp_ill_d;
    logic              memwrite_q, memwrite_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [TYPE_W-1:0] load_type_q, load_type_d;
    logic [TYPE_W-1:0] store_type_q, store_type_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

    logic              req_illegal_c, req_mis_c, req_word_c;
    logic [TYPE_W-1:0] req_type_c;
    logic [1:0]        beat_nxt_c;
    logic [XLEN-1:0]   asm_c, ext_c;

    // Request decode: access width, alignment and legality of funct3
    always_comb begin
        req_word_c    = (req_funct3[1:0] == 2'b10);
        req_illegal_c = req_we ? (req_funct3 >= 3'b011)
                               : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
        req_mis_c     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        (req_word_c && (req_addr[1:0] != 2'b00));
        case (req_funct3[1:0])
            2'b00:   req_type_c = TYPE_BYTE;
            2'b01:   req_type_c = TYPE_HALF;
            default: req_type_c = TYPE_WORD;
        endcase
    end

    // Merge the current beat's byte into the partial result, then extend
    always_comb begin
        beat_nxt_c = beat_q + 2'd1;
        asm_c      = acc_q;
        asm_c[{beat_q, 3'b000} +: 8] = mem_rdata[7:0];
        if (!split_q) begin
            asm_c = mem_rdata;
        end
        case (f3_q)
            3'b000:  ext_c = {{24{asm_c[7]}}, asm_c[7:0]};
            3'b001:  ext_c = {{16{asm_c[15]}}, asm_c[15:0]};
            3'b100:  ext_c = {24'd0, asm_c[7:0]};
            3'b101:  ext_c = {16'd0, asm_c[15:0]};
            default: ext_c = asm_c;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        f3_d         = f3_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        acc_d        = acc_q;
        split_d      = split_q;
        beat_d       = beat_q;
        last_beat_d  = last_beat_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_mis_d   = resp_mis_q;
        resp_ill_d   = resp_ill_q;
        memwrite_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        load_type_d  = load_type_q;
        store_type_d = store_type_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d        = req_funct3;
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    beat_d      = 2'd0;
                    req_ready_d = 1'b0;
                    if (req_illegal_c || (req_mis_c && !SPLIT_MISALIGNED)) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_mis_d   = req_mis_c && !req_illegal_c;
                        resp_ill_d   = req_illegal_c;
                    end else begin
                        state_d      = ACCESS;
                        split_d      = req_mis_c;
                        last_beat_d  = req_mis_c ? (req_word_c ? 2'd3 : 2'd1) : 2'd0;
                        memwrite_d   = req_we;
                        mem_addr_d   = req_addr;
                        load_type_d  = req_mis_c ? TYPE_BYTE : req_type_c;
                        store_type_d = req_mis_c ? TYPE_BYTE : req_type_c;
                        if (req_we) begin
                            mem_wdata_d = req_mis_c ? {24'd0, req_wdata[7:0]} : req_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                if (beat_q != last_beat_q) begin
                    beat_d     = beat_nxt_c;
                    acc_d      = asm_c;
                    memwrite_d = we_q;
                    mem_addr_d = addr_q + 32'(beat_nxt_c);
                    if (we_q) begin
                        mem_wdata_d = {24'd0, wdata_q[{beat_nxt_c, 3'b000} +: 8]};
                    end
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'd0 : ext_c;
                    resp_mis_d   = 1'b0;
                    resp_ill_d   = 1'b0;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            f3_q         <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            acc_q        <= '0;
            split_q      <= 1'b0;
            beat_q       <= '0;
            last_beat_q  <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
            resp_ill_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            mem_addr_q   <= '0;
            load_type_q  <= TYPE_WORD;
            store_type_q <= TYPE_WORD;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            acc_q        <= acc_d;
            split_q      <= split_d;
            beat_q       <= beat_d;
            last_beat_q  <= last_beat_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
            resp_ill_q   <= resp_ill_d;
            memwrite_q   <= memwrite_d;
            mem_addr_q   <= mem_addr_d;
            load_type_q  <= load_type_d;
            store_type_q <= store_type_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;
    assign resp_illegal    = resp_ill_q;
    assign memwrite        = memwrite_q;
    assign mem_addr        = mem_addr_q;
    assign load_type       = load_type_q;
    assign store_type      = store_type_q;
    assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a split instance backed by a byte memory
// model and a non-split instance for misaligned reporting.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, ns_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_misaligned, resp_illegal, memwrite;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  load_type, store_type;

    logic        ns_ready, ns_rvalid, ns_mis, ns_ill, ns_mw;
    logic [31:0] ns_rdata, ns_addr, ns_wdata, ns_mrdata;
    logic [1:0]  ns_lt, ns_st;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [256];

    // Per-transaction observation log (index = cycles after accept)
    int          lat;
    logic        l_mw [10];
    logic [31:0] l_ad [10];
    logic [1:0]  l_lt [10];
    logic [1:0]  l_st [10];
    logic [31:0] l_wd [10];
    logic [31:0] r_rd, r_addr;
    logic        r_mis, r_ill, r_mw, r_rdy, r_rdy_next, r_rdy_issue;

    always #5 clk = ~clk;

    load_store_unit #(.SPLIT_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
        .memwrite(memwrite), .mem_addr(mem_addr), .load_type(load_type),
        .store_type(store_type), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.SPLIT_MISALIGNED(1'b0)) u_ns (
        .clk(clk), .resetn(resetn),
        .req_valid(ns_valid), .req_ready(ns_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(ns_rvalid), .resp_rdata(ns_rdata),
        .resp_misaligned(ns_mis), .resp_illegal(ns_ill),
        .memwrite(ns_mw), .mem_addr(ns_addr), .load_type(ns_lt),
        .store_type(ns_st), .mem_wdata(ns_wdata), .mem_rdata(ns_mrdata)
    );

    function automatic logic [31:0] rd(input logic [31:0] a, input logic [1:0] t);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[a[7:0]];
        b1 = mem[8'(a[7:0] + 8'd1)];
        b2 = mem[8'(a[7:0] + 8'd2)];
        b3 = mem[8'(a[7:0] + 8'd3)];
        case (t)
            2'b00:   rd = {b3, b2, b1, b0};
            2'b01:   rd = {16'd0, b1, b0};
            default: rd = {24'd0, b0};
        endcase
    endfunction

    always_comb mem_rdata = rd(mem_addr, load_type);
    always_comb ns_mrdata = rd(ns_addr, ns_lt);

    // Little-endian byte memory; written by the split instance only
    always @(posedge clk) begin
        if (memwrite) begin
            mem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (store_type != 2'b10) mem[8'(mem_addr[7:0] + 8'd1)] <= mem_wdata[15:8];
            if (store_type == 2'b00) begin
                mem[8'(mem_addr[7:0] + 8'd2)] <= mem_wdata[23:16];
                mem[8'(mem_addr[7:0] + 8'd3)] <= mem_wdata[31:24];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one request at a negedge and log until resp_valid (bounded)
    task automatic issue(input bit ns, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        r_rdy_issue = ns ? ns_ready : req_ready;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        if (ns) ns_valid = 1'b1; else req_valid = 1'b1;
        cyc();
        req_valid = 1'b0; ns_valid = 1'b0;
        lat = 99;
        for (int n = 1; n < 10; n++) begin
            if ((ns ? ns_rvalid : resp_valid) === 1'b1) begin
                lat = n;
                break;
            end
            l_mw[n] = ns ? ns_mw : memwrite;
            l_ad[n] = ns ? ns_addr : mem_addr;
            l_lt[n] = ns ? ns_lt : load_type;
            l_st[n] = ns ? ns_st : store_type;
            l_wd[n] = ns ? ns_wdata : mem_wdata;
            cyc();
        end
        r_rd   = ns ? ns_rdata : resp_rdata;
        r_mis  = ns ? ns_mis : resp_misaligned;
        r_ill  = ns ? ns_ill : resp_illegal;
        r_mw   = ns ? ns_mw : memwrite;
        r_rdy  = ns ? ns_ready : req_ready;
        r_addr = ns ? ns_addr : mem_addr;
        cyc();
        r_rdy_next = ns ? ns_ready : req_ready;
    endtask

    task automatic test_reset();
        total += 8;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        if (resp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
        if (memwrite !== 1'b0) begin bad++; $display("FAIL rst_memwrite got=%b exp=0", memwrite); end
        if (mem_addr !== 32'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        if (load_type !== 2'b00) begin bad++; $display("FAIL rst_load_type got=%b exp=00", load_type); end
        if (store_type !== 2'b00) begin bad++; $display("FAIL rst_store_type got=%b exp=00", store_type); end
        if (mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
    endtask

    task automatic test_aligned();
        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        total += 8;
        if (r_rdy_issue !== 1'b1) begin bad++; $display("FAIL sw_ready got=%b exp=1", r_rdy_issue); end
        if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        if (l_mw[1] !== 1'b1) begin bad++; $display("FAIL sw_memwrite got=%b exp=1", l_mw[1]); end
        if (l_ad[1] !== 32'h10) begin bad++; $display("FAIL sw_addr got=%h exp=10", l_ad[1]); end
        if (l_st[1] !== 2'b00) begin bad++; $display("FAIL sw_type got=%b exp=00", l_st[1]); end
        if (l_wd[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", l_wd[1]); end
        if (r_mw !== 1'b0) begin bad++; $display("FAIL sw_memwrite_resp got=%b exp=0", r_mw); end
        if (r_rd !== 32'd0) begin bad++; $display("FAIL sw_rdata got=%h exp=0", r_rd); end

        issue(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        total += 6;
        if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        if (l_mw[1] !== 1'b0) begin bad++; $display("FAIL lw_memwrite got=%b exp=0", l_mw[1]); end
        if (l_lt[1] !== 2'b00) begin bad++; $display("FAIL lw_type got=%b exp=00", l_lt[1]); end
        if (r_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", r_rd); end
        if (r_rdy !== 1'b0) begin bad++; $display("FAIL lw_ready_resp got=%b exp=0", r_rdy); end
        if (r_rdy_next !== 1'b1) begin bad++; $display("FAIL lw_ready_after got=%b exp=1", r_rdy_next); end
    endtask

    task automatic test_extend();
        logic [2:0]  f3  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b101};
        logic [31:0] ad  [7] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h80, 32'h82, 32'h82};
        logic [31:0] exp [7] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD,
                                 32'h0000005A, 32'hFFFF8001, 32'h00008001};
        logic [1:0]  ty  [7] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
        issue(1'b0, 1'b1, 3'b000, 32'h80, 32'h1234565A);
        total++;
        if (l_st[1] !== 2'b10) begin bad++; $display("FAIL sb_type got=%b exp=10", l_st[1]); end
        issue(1'b0, 1'b1, 3'b001, 32'h82, 32'h77778001);
        total++;
        if (l_st[1] !== 2'b01) begin bad++; $display("FAIL sh_type got=%b exp=01", l_st[1]); end
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, 1'b0, f3[i], ad[i], 32'h0);
            total += 3;
            if (lat !== 2) begin bad++; $display("FAIL ext%0d_latency got=%0d exp=2", i, lat); end
            if (l_lt[1] !== ty[i]) begin bad++; $display("FAIL ext%0d_type got=%b exp=%b", i, l_lt[1], ty[i]); end
            if (r_rd !== exp[i]) begin bad++; $display("FAIL ext%0d_rdata got=%h exp=%h", i, r_rd, exp[i]); end
        end
    endtask

    task automatic test_split();
        logic [31:0] sdat;
        issue(1'b0, 1'b1, 3'b010, 32'h21, 32'h11223344);
        sdat = 32'h11223344;
        total += 2;
        if (lat !== 5) begin bad++; $display("FAIL ssw_latency got=%0d exp=5", lat); end
        if (r_mis !== 1'b0) begin bad++; $display("FAIL ssw_misaligned got=%b exp=0", r_mis); end
        for (int i = 0; i < 4; i++) begin
            total += 4;
            if (l_mw[i+1] !== 1'b1) begin bad++; $display("FAIL ssw_mw%0d got=%b exp=1", i, l_mw[i+1]); end
            if (l_ad[i+1] !== 32'h21 + 32'(i)) begin bad++; $display("FAIL ssw_addr%0d got=%h exp=%h", i, l_ad[i+1], 32'h21 + 32'(i)); end
            if (l_st[i+1] !== 2'b10) begin bad++; $display("FAIL ssw_type%0d got=%b exp=10", i, l_st[i+1]); end
            if (l_wd[i+1] !== {24'd0, sdat[8*i +: 8]}) begin bad++; $display("FAIL ssw_wdata%0d got=%h exp=%h", i, l_wd[i+1], {24'd0, sdat[8*i +: 8]}); end
        end
        issue(1'b0, 1'b0, 3'b010, 32'h21, 32'h0);
        total += 3;
        if (lat !== 5) begin bad++; $display("FAIL slw_latency got=%0d exp=5", lat); end
        if (l_lt[2] !== 2'b10) begin bad++; $display("FAIL slw_type got=%b exp=10", l_lt[2]); end
        if (r_rd !== 32'h11223344) begin bad++; $display("FAIL slw_rdata got=%h exp=11223344", r_rd); end

        issue(1'b0, 1'b1, 3'b001, 32'h31, 32'h0000BEEF);
        total += 2;
        if (lat !== 3) begin bad++; $display("FAIL ssh_latency got=%0d exp=3", lat); end
        if (l_wd[2] !== 32'h000000BE) begin bad++; $display("FAIL ssh_wdata1 got=%h exp=be", l_wd[2]); end
        issue(1'b0, 1'b0, 3'b001, 32'h31, 32'h0);
        total += 2;
        if (lat !== 3) begin bad++; $display("FAIL slh_latency got=%0d exp=3", lat); end
        if (r_rd !== 32'hFFFFBEEF) begin bad++; $display("FAIL slh_rdata got=%h exp=ffffbeef", r_rd); end
        issue(1'b0, 1'b0, 3'b101, 32'h31, 32'h0);
        total++;
        if (r_rd !== 32'h0000BEEF) begin bad++; $display("FAIL slhu_rdata got=%h exp=0000beef", r_rd); end

        // Address wrap across 2^32
        issue(1'b0, 1'b1, 3'b010, 32'hFFFFFFFF, 32'hCAFEF00D);
        total += 2;
        if (l_ad[2] !== 32'h0) begin bad++; $display("FAIL wrap_addr1 got=%h exp=0", l_ad[2]); end
        if (l_ad[4] !== 32'h2) begin bad++; $display("FAIL wrap_addr3 got=%h exp=2", l_ad[4]); end
        issue(1'b0, 1'b0, 3'b010, 32'hFFFFFFFF, 32'h0);
        total++;
        if (r_rd !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap_rdata got=%h exp=cafef00d", r_rd); end
    endtask

    task automatic test_nosplit();
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        total += 2;
        if (lat !== 2) begin bad++; $display("FAIL ns_lw_latency got=%0d exp=2", lat); end
        if (r_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ns_lw_rdata got=%h exp=deadbeef", r_rd); end
        issue(1'b1, 1'b0, 3'b001, 32'h5, 32'h0);
        total += 6;
        if (lat !== 1) begin bad++; $display("FAIL ns_lh_latency got=%0d exp=1", lat); end
        if (r_mis !== 1'b1) begin bad++; $display("FAIL ns_lh_misaligned got=%b exp=1", r_mis); end
        if (r_ill !== 1'b0) begin bad++; $display("FAIL ns_lh_illegal got=%b exp=0", r_ill); end
        if (r_rd !== 32'd0) begin bad++; $display("FAIL ns_lh_rdata got=%h exp=0", r_rd); end
        if (r_mw !== 1'b0) begin bad++; $display("FAIL ns_lh_memwrite got=%b exp=0", r_mw); end
        if (r_addr !== 32'h10) begin bad++; $display("FAIL ns_lh_addr_hold got=%h exp=10", r_addr); end
        issue(1'b1, 1'b1, 3'b010, 32'h2, 32'h55667788);
        total += 3;
        if (lat !== 1) begin bad++; $display("FAIL ns_sw_latency got=%0d exp=1", lat); end
        if (r_mis !== 1'b1) begin bad++; $display("FAIL ns_sw_misaligned got=%b exp=1", r_mis); end
        if (r_mw !== 1'b0) begin bad++; $display("FAIL ns_sw_memwrite got=%b exp=0", r_mw); end
    endtask

    task automatic test_illegal();
        logic        we [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  f3 [3] = '{3'b011, 3'b110, 3'b011};
        issue(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, we[i], f3[i], 32'h10, 32'h0);
            total += 7;
            if (lat !== 1) begin bad++; $display("FAIL ill%0d_latency got=%0d exp=1", i, lat); end
            if (r_ill !== 1'b1) begin bad++; $display("FAIL ill%0d_flag got=%b exp=1", i, r_ill); end
            if (r_mis !== 1'b0) begin bad++; $display("FAIL ill%0d_misaligned got=%b exp=0", i, r_mis); end
            if (r_rd !== 32'd0) begin bad++; $display("FAIL ill%0d_rdata got=%h exp=0", i, r_rd); end
            if (r_mw !== 1'b0) begin bad++; $display("FAIL ill%0d_memwrite got=%b exp=0", i, r_mw); end
            if (r_rdy !== 1'b0) begin bad++; $display("FAIL ill%0d_ready_n1 got=%b exp=0", i, r_rdy); end
            if (r_rdy_next !== 1'b1) begin bad++; $display("FAIL ill%0d_ready_n2 got=%b exp=1", i, r_rdy_next); end
        end
    endtask

    task automatic test_back_to_back();
        // Next request issued in the cycle right after resp_valid; flags clear
        issue(1'b0, 1'b0, 3'b111, 32'h10, 32'h0);
        issue(1'b0, 1'b0, 3'b100, 32'h10, 32'h0);
        total += 4;
        if (r_rdy_issue !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", r_rdy_issue); end
        if (lat !== 2) begin bad++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
        if (r_ill !== 1'b0) begin bad++; $display("FAIL b2b_illegal_clear got=%b exp=0", r_ill); end
        if (r_rd !== 32'h000000EF) begin bad++; $display("FAIL b2b_rdata got=%h exp=ef", r_rd); end
    endtask

    task automatic test_reset_mid();
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h41; req_wdata = 32'hAABBCCDD;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        cyc();
        total += 2;
        if (memwrite !== 1'b1) begin bad++; $display("FAIL rm_beat2_mw got=%b exp=1", memwrite); end
        if (mem_addr !== 32'h42) begin bad++; $display("FAIL rm_beat2_addr got=%h exp=42", mem_addr); end
        resetn = 1'b0;
        #1;
        total += 3;
        if (memwrite !== 1'b0) begin bad++; $display("FAIL rm_memwrite got=%b exp=0", memwrite); end
        if (req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", req_ready); end
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL rm_resp_valid got=%b exp=0", resp_valid); end
        cyc();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if (resp_valid !== 1'b0) begin bad++; $display("FAIL rm_no_resp%0d got=%b exp=0", i, resp_valid); end
        end
        total += 2;
        if (mem[8'h41] !== 8'hDD) begin bad++; $display("FAIL rm_beat1_written got=%h exp=dd", mem[8'h41]); end
        if (mem[8'h42] !== 8'h00) begin bad++; $display("FAIL rm_beat2_dropped got=%h exp=00", mem[8'h42]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        resetn = 1'b0; req_valid = 1'b0; ns_valid = 1'b0;
        req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) cyc();
        resetn = 1'b1;
        cyc();
        test_reset();
        test_aligned();
        test_extend();
        test_split();
        test_nosplit();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
